// File: rtl/paratoserial_tx_if.sv
// paratoserial_tx_if: parallel word input and serial/status outputs of the serializer
interface paratoserial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       word_req;
  logic       out;
  logic       active;
  logic       err_bc;
  modport master (output data_in, valid_in, input word_req, out, active, err_bc);
  modport slave (input data_in, valid_in, output word_req, out, active, err_bc);
endinterface

// File: rtl/paratoserial_tx.sv
// paratoserial_tx: 8:1 serializer sending SYNC_WORDS commas after reset, then data or comma fill
module paratoserial_tx #(
  parameter int         SYNC_WORDS = 8,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input logic             clk_8f,
  input logic             reset,
  paratoserial_tx_if.slave bus
);
  typedef enum logic {SYNC, ACTIVE} state_t;
  state_t     state;
  logic [2:0] phase;
  logic [7:0] sh;
  logic [3:0] cnt;
  logic       load;
  logic [7:0] word;
  logic       bc_hit;
  assign load         = phase == 3'd7;
  assign bus.word_req = load && !reset;
  assign bus.out      = sh[7];
  assign word         = (state == ACTIVE && bus.valid_in) ? bus.data_in : COMMA;
  assign bc_hit       = state == ACTIVE && bus.valid_in && bus.data_in == COMMA;
  // phase counter, shift register and sync/active state machine
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      phase      <= 3'd7;
      sh         <= 8'd0;
      state      <= SYNC;
      cnt        <= 4'd0;
      bus.active <= 1'b0;
      bus.err_bc <= 1'b0;
    end else begin
      phase <= phase + 3'd1;
      sh    <= load ? word : {sh[6:0], 1'b0};
      if (load && state == SYNC) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'(SYNC_WORDS - 1)) begin
          state      <= ACTIVE;
          bus.active <= 1'b1;
        end
      end
      if (load && bc_hit) bus.err_bc <= 1'b1;
    end
  end
endmodule

// File: tb/tb_paratoserial_tx.sv
// tb_paratoserial_tx: table, hand-written and random checks against a word-level reference model
module tb_paratoserial_tx;
  localparam int         SW    = 8;
  localparam logic [7:0] COMMA = 8'hBC;
  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  paratoserial_tx_if bus();
  paratoserial_tx #(.SYNC_WORDS(SW), .COMMA(COMMA)) dut (.clk_8f(clk_8f), .reset(reset), .bus(bus));
  always #5 clk_8f = ~clk_8f;
  typedef struct {logic v; logic [7:0] d; logic [7:0] exp;} vec_t;
  vec_t       tbl[6];
  int         total = 0;
  int         passed = 0;
  int         n = 0;
  int         rise = 0;
  int         bad;
  logic [7:0] mword = 8'd0;
  logic       merr = 1'b0;
  logic [7:0] got = 8'd0;
  logic       rv;
  logic [7:0] rd;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask
  // one clock: drive inputs, check word_req, advance the model by one edge, check outputs
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic eo, ea;
    reset = r;
    bus.valid_in = v;
    bus.data_in = d;
    #1 check("word_req", 8'(bus.word_req), 8'(!r && n % 8 == 0));
    @(posedge clk_8f);
    #1;
    if (r) begin
      n = 0; merr = 1'b0; mword = 8'd0; rise = 0; eo = 1'b0; ea = 1'b0;
    end else begin
      if (n % 8 == 0) begin
        mword = (n / 8 + 1 <= SW || !v) ? COMMA : d;
        if (n / 8 + 1 > SW && v && d == COMMA) merr = 1'b1;
      end
      eo = mword[3'(7 - n % 8)];
      ea = n + 1 >= 8 * SW - 7;
      n++;
      if (bus.active && rise == 0) rise = n;
    end
    check("out", 8'(bus.out), 8'(eo));
    check("active", 8'(bus.active), 8'(ea));
    check("err_bc", 8'(bus.err_bc), 8'(merr));
    got = {got[6:0], bus.out};
  endtask
  task automatic send(input logic v, input logic [7:0] d);
    step(1'b0, v, d);
    repeat (7) step(1'b0, 1'($urandom), 8'($urandom));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl = '{'{1'b1, 8'h3C, 8'h3C}, '{1'b0, 8'h77, COMMA}, '{1'b1, 8'h00, 8'h00},
            '{1'b1, 8'hFF, 8'hFF}, '{1'b1, 8'h01, 8'h01}, '{1'b0, 8'h55, COMMA}};
    bus.valid_in = 1'b0;
    bus.data_in = 8'd0;
    repeat (3) step(1'b1, 1'($urandom), 8'($urandom));
    repeat (SW) begin
      send(1'b1, 8'hA5);
      check("sync_word", got, COMMA);
    end
    check("active_rise_edge", 8'(rise), 8'(8 * SW - 7));
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].v, tbl[i].d);
      check("tbl_word", got, tbl[i].exp);
    end
    send(1'b1, COMMA);
    check("err_word", got, COMMA);
    check("err_set", 8'(bus.err_bc), 8'd1);
    send(1'b1, 8'h11);
    check("err_sticky", 8'(bus.err_bc), 8'd1);
    repeat (40) begin
      rv = 1'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom);
      send(rv, rd);
      check("rand_word", got, rv ? rd : COMMA);
    end
    step(1'b0, 1'b1, 8'hF0);
    repeat (3) step(1'b0, 1'($urandom), 8'($urandom));
    step(1'b1, 1'b1, 8'hF0);
    check("rst_out", 8'(bus.out), 8'd0);
    check("rst_active", 8'(bus.active), 8'd0);
    check("rst_err", 8'(bus.err_bc), 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("resync_msb", 8'(bus.out), 8'd1);
    repeat (7) step(1'b0, 1'b1, 8'hF0);
    check("resync_word", got, COMMA);
    repeat (SW - 1) send(1'b0, 8'd0);
    bad = 0;
    for (int k = 1; k < 256; k++) begin
      send(1'b1, 8'(k));
      if (got != 8'(k)) bad++;
    end
    check("loopback_errors", 8'(bad), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
